// File: rtl/sys_rst_pkg.sv
// Shared types and constants for the system reset controller:
// FSM state encoding, reset-cause bit positions and a small helper.
package sys_rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT   = 2'd0,
        ST_RUN      = 2'd1,
        ST_LOCKWAIT = 2'd2
    } rst_state_e;

    localparam int CAUSE_W    = 4;
    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_SYS  = 1;
    localparam int CAUSE_LOCK = 2;
    localparam int CAUSE_EXT  = 3;

    localparam logic [CAUSE_W-1:0] POR_CAUSE = CAUSE_W'(1) << CAUSE_POR;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_hold_timer.sv
// Loadable down-counter shared by the reset-hold and lockup-wait phases.
// Load has priority over decrement; the count stops at zero.
module rst_hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/sys_reset_ctrl.sv
// Warm-reset controller: turns SYSRESETREQ, sustained LOCKUP or an external
// request into a fixed-width sys_rst_n pulse, with sticky causes and a counter.
module sys_reset_ctrl
    import sys_rst_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int LOCKUP_TIMEOUT = 32,
    parameter int CNT_W          = 8
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               SYSRESETREQ,
    input  logic               LOCKUP,
    input  logic               ext_rst_req,
    input  logic               cause_clr,
    output logic               sys_rst_n,
    output logic               in_reset,
    output logic [CAUSE_W-1:0] rst_cause,
    output logic [CNT_W-1:0]   rst_count
);

    localparam int TMR_W = (max_int(HOLD_CYCLES, LOCKUP_TIMEOUT) > 1)
                         ? $clog2(max_int(HOLD_CYCLES, LOCKUP_TIMEOUT)) : 1;
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    // The RUN edge that first sees LOCKUP counts as sample one, so the wait
    // phase needs two fewer steps than the timeout to fire on the last sample.
    localparam logic [TMR_W-1:0] LOCK_LOAD =
        TMR_W'((LOCKUP_TIMEOUT >= 2) ? (LOCKUP_TIMEOUT - 2) : 0);
    localparam logic LOCK_IMMEDIATE = (LOCKUP_TIMEOUT == 1);

    rst_state_e         r_state;
    rst_state_e         w_state_next;
    logic               r_sys_rst_n;
    logic [CAUSE_W-1:0] r_cause;
    logic [CNT_W-1:0]   r_count;

    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_dec;
    logic               w_tmr_zero;
    logic               w_req;
    logic               w_lock_fire;
    logic               w_warm_entry;
    logic [CAUSE_W-1:0] w_new_cause;

    rst_hold_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (HCLK),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .dec      (w_tmr_dec),
        .zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = HOLD_LOAD;
        w_tmr_dec    = 1'b0;
        w_warm_entry = 1'b0;
        w_lock_fire  = 1'b0;
        w_new_cause  = '0;
        w_req        = SYSRESETREQ | ext_rst_req;

        case (r_state)
            ST_ASSERT: begin
                if (w_tmr_zero) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_RUN: begin
                w_lock_fire = LOCK_IMMEDIATE && LOCKUP;
                if (w_req || w_lock_fire) begin
                    w_state_next = ST_ASSERT;
                    w_tmr_load   = 1'b1;
                    w_warm_entry = 1'b1;
                end else if (LOCKUP) begin
                    w_state_next = ST_LOCKWAIT;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = LOCK_LOAD;
                end
            end
            ST_LOCKWAIT: begin
                w_lock_fire = LOCKUP && w_tmr_zero;
                if (w_req || w_lock_fire) begin
                    w_state_next = ST_ASSERT;
                    w_tmr_load   = 1'b1;
                    w_warm_entry = 1'b1;
                end else if (!LOCKUP) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_ASSERT;
                w_tmr_load   = 1'b1;
            end
        endcase

        if (w_warm_entry) begin
            w_new_cause[CAUSE_SYS]  = SYSRESETREQ;
            w_new_cause[CAUSE_EXT]  = ext_rst_req;
            w_new_cause[CAUSE_LOCK] = w_lock_fire;
        end

        // Power-on reset reloads the hold time regardless of the FSM.
        if (!HRESETn) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = HOLD_LOAD;
            w_tmr_dec  = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state     <= ST_ASSERT;
            r_sys_rst_n <= 1'b0;
            r_cause     <= POR_CAUSE;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sys_rst_n <= (w_state_next != ST_ASSERT);
            // New causes win over a simultaneous clear.
            if (w_warm_entry) begin
                r_cause <= (cause_clr ? '0 : r_cause) | w_new_cause;
            end else if (cause_clr && (r_state != ST_ASSERT)) begin
                r_cause <= '0;
            end
            if (w_warm_entry && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign sys_rst_n = r_sys_rst_n;
    assign in_reset  = (r_state == ST_ASSERT);
    assign rst_cause = r_cause;
    assign rst_count = r_count;

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// Directed bench for sys_reset_ctrl: each reset pulse is predicted (width,
// final cause, final count) when stimulated and checked when it ends.
module tb_sys_reset_ctrl;

    localparam int HOLD = 16;
    localparam int LTO  = 32;

    logic       HCLK;
    logic       HRESETn;
    logic       SYSRESETREQ;
    logic       LOCKUP;
    logic       ext_rst_req;
    logic       cause_clr;
    logic       sys_rst_n;
    logic       in_reset;
    logic [3:0] rst_cause;
    logic [7:0] rst_count;

    sys_reset_ctrl #(
        .HOLD_CYCLES    (HOLD),
        .LOCKUP_TIMEOUT (LTO),
        .CNT_W          (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .SYSRESETREQ (SYSRESETREQ),
        .LOCKUP      (LOCKUP),
        .ext_rst_req (ext_rst_req),
        .cause_clr   (cause_clr),
        .sys_rst_n   (sys_rst_n),
        .in_reset    (in_reset),
        .rst_cause   (rst_cause),
        .rst_count   (rst_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        int         id;
        int         width;
        logic [3:0] cause;
        logic [7:0] count;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   low_cnt     = 0;
    int   pulses_done = 0;
    int   next_id     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input int width, input logic [3:0] cause, input logic [7:0] count);
        exp_t e;
        e.id    = next_id;
        e.width = width;
        e.cause = cause;
        e.count = count;
        next_id++;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic wait_pulses(input int target);
        int n = 0;
        while (pulses_done < target && n < 40) begin
            @(negedge HCLK);
            n++;
        end
        check("pulse_timeout", 32'(pulses_done >= target), 32'd1);
    endtask

    // Pulse monitor: measures each low window and retires one prediction.
    always @(negedge HCLK) begin
        if (sys_rst_n === 1'b0) begin
            low_cnt++;
        end else if (sys_rst_n === 1'b1 && low_cnt > 0) begin
            check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("pulse_width", 32'(low_cnt), 32'(mon_e.width));
                check("pulse_cause", 32'(rst_cause), 32'(mon_e.cause));
                check("pulse_count", 32'(rst_count), 32'(mon_e.count));
                $display("pulse %0d: width %0d cause %b count %0d", mon_e.id, low_cnt, rst_cause, rst_count);
            end
            pulses_done++;
            low_cnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        HRESETn     = 1'b0;
        SYSRESETREQ = 1'b0;
        LOCKUP      = 1'b0;
        ext_rst_req = 1'b0;
        cause_clr   = 1'b0;

        // Power-on reset: 10 edges low, then a 16-cycle hold counted from the last
        // reset edge, so the monitor sees 10 + 15 low samples.
        tick(10);
        check("por_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("por_in_reset", 32'(in_reset), 32'd1);
        check("por_cause", 32'(rst_cause), 32'h1);
        check("por_count", 32'(rst_count), 32'd0);
        push_exp(10 + HOLD - 1, 4'b0001, 8'd0);
        HRESETn = 1'b1;
        tick(HOLD - 1);
        check("por_hold_last", 32'(sys_rst_n), 32'd0);
        tick(1);
        check("por_release", 32'(sys_rst_n), 32'd1);
        check("por_in_reset_off", 32'(in_reset), 32'd0);
        tick(2);

        // One-cycle SYSRESETREQ.
        SYSRESETREQ = 1'b1;
        push_exp(HOLD, 4'b0011, 8'd1);
        tick(1);
        check("sys_fall", 32'(sys_rst_n), 32'd0);
        check("sys_in_reset", 32'(in_reset), 32'd1);
        SYSRESETREQ = 1'b0;
        tick(HOLD - 1);
        check("sys_hold_last", 32'(sys_rst_n), 32'd0);
        tick(1);
        check("sys_release", 32'(sys_rst_n), 32'd1);
        tick(2);
        cause_clr = 1'b1;
        tick(1);
        cause_clr = 1'b0;
        check("clr_cause", 32'(rst_cause), 32'h0);

        // LOCKUP for one sample short of the timeout: no reset.
        LOCKUP = 1'b1;
        tick(LTO - 1);
        LOCKUP = 1'b0;
        tick(1);
        check("lock31_no_reset", 32'(sys_rst_n), 32'd1);
        check("lock31_cause", 32'(rst_cause), 32'h0);
        check("lock31_count", 32'(rst_count), 32'd1);
        tick(3);

        // LOCKUP for the full timeout: reset on the 32nd sample.
        LOCKUP = 1'b1;
        push_exp(HOLD, 4'b0100, 8'd2);
        tick(LTO - 1);
        check("lock32_before", 32'(sys_rst_n), 32'd1);
        tick(1);
        check("lock32_fall", 32'(sys_rst_n), 32'd0);
        LOCKUP = 1'b0;
        tick(HOLD);
        check("lock32_release", 32'(sys_rst_n), 32'd1);
        tick(2);

        // Coincident SYSRESETREQ + ext request with cause_clr: set wins, one count.
        SYSRESETREQ = 1'b1;
        ext_rst_req = 1'b1;
        cause_clr   = 1'b1;
        push_exp(HOLD, 4'b1010, 8'd3);
        tick(1);
        check("dual_fall", 32'(sys_rst_n), 32'd0);
        SYSRESETREQ = 1'b0;
        ext_rst_req = 1'b0;
        cause_clr   = 1'b0;
        tick(HOLD);
        check("dual_release", 32'(sys_rst_n), 32'd1);
        tick(2);

        // HRESETn at cycle 5 of a warm hold: 5 warm + 1 reset + 15 hold samples.
        SYSRESETREQ = 1'b1;
        push_exp(5 + 1 + HOLD - 1, 4'b0001, 8'd0);
        tick(1);
        SYSRESETREQ = 1'b0;
        tick(4);
        HRESETn = 1'b0;
        tick(1);
        check("midrst_count", 32'(rst_count), 32'd0);
        check("midrst_cause", 32'(rst_cause), 32'h1);
        check("midrst_in_reset", 32'(in_reset), 32'd1);
        HRESETn = 1'b1;
        tick(HOLD - 1);
        check("midrst_hold_last", 32'(sys_rst_n), 32'd0);
        tick(1);
        check("midrst_release", 32'(sys_rst_n), 32'd1);
        tick(2);

        // 260 back-to-back warm resets from a held request: counter saturates.
        base = pulses_done;
        SYSRESETREQ = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            push_exp(HOLD, 4'b0011, (i > 255) ? 8'd255 : 8'(i));
            wait_pulses(base + i);
            if (i == 259) begin
                @(posedge HCLK);
                #1;
                SYSRESETREQ = 1'b0;
            end
        end
        check("sat_count", 32'(rst_count), 32'd255);
        tick(20);
        check("sat_idle", 32'(sys_rst_n), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
